// File: rtl/zion_dat_read_track_if.sv
// Bus bundle for zion_dat_read_track: load requests in, word reads out to memory,
// in-order read data back, and the {oEn, oAddr, oDat} triple out to the sub-word selector.
interface zion_dat_read_track_if #(
  parameter int WIDTH_TYPE_NUM = 2,
  parameter int WIDTH_ADDR     = 2,
  parameter int WIDTH_BUS_ADDR = 32,
  parameter int WIDTH_DATA     = 32
);
  logic                      iReqVld;
  logic                      oReqRdy;
  logic [WIDTH_BUS_ADDR-1:0] iReqAddr;
  logic [WIDTH_TYPE_NUM-1:0] iReqType;
  logic                      oMemVld;
  logic                      iMemRdy;
  logic [WIDTH_BUS_ADDR-1:0] oMemAddr;
  logic                      iRspVld;
  logic [WIDTH_DATA-1:0]     iRspDat;
  logic                      oVld;
  logic [WIDTH_TYPE_NUM-1:0] oEn;
  logic [WIDTH_ADDR-1:0]     oAddr;
  logic [WIDTH_DATA-1:0]     oDat;
  logic                      oErr;

  modport slave (
    input  iReqVld, iReqAddr, iReqType, iMemRdy, iRspVld, iRspDat,
    output oReqRdy, oMemVld, oMemAddr, oVld, oEn, oAddr, oDat, oErr
  );

  modport master (
    output iReqVld, iReqAddr, iReqType, iMemRdy, iRspVld, iRspDat,
    input  oReqRdy, oMemVld, oMemAddr, oVld, oEn, oAddr, oDat, oErr
  );
endinterface

// File: rtl/zion_dat_read_track.sv
// In-order load tracker feeding the DatRead sub-word selector.
// Optional macro ZION_DAT_READ_TRACK_CHECK_EN: sticky oErr on stray responses plus protocol assertions.
module zion_dat_read_track #(
  parameter int WIDTH_TYPE_NUM = 2,
  parameter int WIDTH_ADDR     = 2,
  parameter int WIDTH_BUS_ADDR = 32,
  parameter int WIDTH_DATA     = 32,
  parameter int DEPTH          = 4
) (
  input logic                   clk,
  input logic                   rst,
  zion_dat_read_track_if.slave  trk_io
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH_TYPE_NUM-1:0] tag_type_q [DEPTH];
  logic [WIDTH_ADDR-1:0]     tag_addr_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      full_s, empty_s, rdy_s, push_s, pop_s;
  logic                      mem_vld_q, mem_vld_d;
  logic [WIDTH_BUS_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic                      vld_q, vld_d;
  logic [WIDTH_TYPE_NUM-1:0] en_q, en_d;
  logic [WIDTH_ADDR-1:0]     addr_q, addr_d;
  logic [WIDTH_DATA-1:0]     dat_q, dat_d;
  logic                      err_q, err_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_s  = (cnt_q == CNT_W'(DEPTH));
  assign empty_s = (cnt_q == CNT_W'(0));
  // A new accept may only replace the memory request once the old one has been taken.
  assign rdy_s   = !full_s && (!mem_vld_q || trk_io.iMemRdy);
  assign push_s  = trk_io.iReqVld && rdy_s;
  assign pop_s   = trk_io.iRspVld && !empty_s;

  // Next-state for occupancy, memory request and output triple.
  always_comb begin
    cnt_d      = cnt_q;
    mem_vld_d  = mem_vld_q;
    mem_addr_d = mem_addr_q;
    vld_d      = 1'b0;
    en_d       = en_q;
    addr_d     = addr_q;
    dat_d      = dat_q;

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (push_s) begin
      mem_vld_d  = 1'b1;
      mem_addr_d = {trk_io.iReqAddr[WIDTH_BUS_ADDR-1:WIDTH_ADDR], {WIDTH_ADDR{1'b0}}};
    end else if (mem_vld_q && trk_io.iMemRdy) begin
      mem_vld_d  = 1'b0;
    end else begin
      mem_vld_d  = mem_vld_q;
    end

    if (pop_s) begin
      vld_d  = 1'b1;
      en_d   = tag_type_q[rd_ptr_q];
      addr_d = tag_addr_q[rd_ptr_q];
      dat_d  = trk_io.iRspDat;
    end else begin
      vld_d  = 1'b0;
    end

`ifdef ZION_DAT_READ_TRACK_CHECK_EN
    err_d = err_q | (trk_io.iRspVld & empty_s);
`else
    err_d = 1'b0;
`endif
  end

  // State registers and tag storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_type_q[i] <= '0;
        tag_addr_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      mem_vld_q  <= 1'b0;
      mem_addr_q <= '0;
      vld_q      <= 1'b0;
      en_q       <= '0;
      addr_q     <= '0;
      dat_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push_s) begin
        tag_type_q[wr_ptr_q] <= trk_io.iReqType;
        tag_addr_q[wr_ptr_q] <= trk_io.iReqAddr[WIDTH_ADDR-1:0];
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q      <= cnt_d;
      mem_vld_q  <= mem_vld_d;
      mem_addr_q <= mem_addr_d;
      vld_q      <= vld_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
    end
  end

  assign trk_io.oReqRdy  = rdy_s;
  assign trk_io.oMemVld  = mem_vld_q;
  assign trk_io.oMemAddr = mem_addr_q;
  assign trk_io.oVld     = vld_q;
  assign trk_io.oEn      = en_q;
  assign trk_io.oAddr    = addr_q;
  assign trk_io.oDat     = dat_q;
  assign trk_io.oErr     = err_q;

`ifdef ZION_DAT_READ_TRACK_CHECK_EN
  zion_dat_read_track_chk #(
    .WIDTH_TYPE_NUM (WIDTH_TYPE_NUM),
    .WIDTH_BUS_ADDR (WIDTH_BUS_ADDR)
  ) u_chk (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push_s),
    .type_i     (trk_io.iReqType),
    .mem_vld_i  (mem_vld_q),
    .mem_rdy_i  (trk_io.iMemRdy),
    .mem_addr_i (mem_addr_q)
  );
`endif

endmodule

`ifdef ZION_DAT_READ_TRACK_CHECK_EN
module zion_dat_read_track_chk #(
  parameter int WIDTH_TYPE_NUM = 2,
  parameter int WIDTH_BUS_ADDR = 32
) (
  input logic                      clk_i,
  input logic                      rst_i,
  input logic                      push_i,
  input logic [WIDTH_TYPE_NUM-1:0] type_i,
  input logic                      mem_vld_i,
  input logic                      mem_rdy_i,
  input logic [WIDTH_BUS_ADDR-1:0] mem_addr_i
);
  a_type_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    push_i |-> $onehot0(type_i));

  a_mem_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_vld_i && !mem_rdy_i) |=> (mem_vld_i && $stable(mem_addr_i)));
endmodule
`endif
